z8_timer: RTL and testbench

Z8-compatible dual timer/counter peripheral (T0, T1) attached to the SoC's special-function-register bus at addresses F1h–F5h. Each channel has a 6-bit prescaler and an 8-bit down-counter. On terminal count a channel emits a one-cycle interrupt request that the SoC's interrupt logic consumes as IRQ4 (T0) and IRQ5 (T1). The block also drives the TOUT pin.

---
 rtl/z8_timer_pkg.sv | 22 ++
 rtl/z8_timer_channel.sv | 59 +++++
 rtl/z8_timer.sv | 118 +++++++++++
 tb/tb_z8_timer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/z8_timer_pkg.sv
// Shared constants for the Z8 dual timer: SFR map, TMR bit positions, TOUT modes.
package z8_timer_pkg;

  localparam logic [7:0] TMR_ADDR  = 8'hF1;
  localparam logic [7:0] T1_ADDR   = 8'hF2;
  localparam logic [7:0] PRE1_ADDR = 8'hF3;
  localparam logic [7:0] T0_ADDR   = 8'hF4;
  localparam logic [7:0] PRE0_ADDR = 8'hF5;

  localparam int TMR_LD0 = 0;
  localparam int TMR_EN0 = 1;
  localparam int TMR_LD1 = 2;
  localparam int TMR_EN1 = 3;

  typedef enum logic [1:0] {
    TOUT_HOLD  = 2'b00,
    TOUT_T0    = 2'b01,
    TOUT_T1    = 2'b10,
    TOUT_HOLD3 = 2'b11
  } tout_mode_e;

endpackage

// File: rtl/z8_timer_channel.sv
// One timer channel: 6-bit prescaler feeding an 8-bit down-counter, with reload
// registers and a continuous/single-pass mode bit.
module z8_timer_channel
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_wr_cnt,
  input  logic       i_wr_pre,
  input  logic [7:0] i_wdata,
  input  logic       i_load,
  input  logic       i_tick,
  input  logic       i_en,
  output logic [7:0] o_count,
  output logic       o_tc,
  output logic       o_done
);

  logic [5:0] r_pre_rld;
  logic [7:0] r_cnt_rld;
  logic       r_cont;
  logic [5:0] r_pre;
  logic [7:0] r_cnt;
  logic       w_dec;

  // Stored value 0 naturally gives 64/256 steps because the decrement wraps.
  assign w_dec   = i_en && i_tick && !i_load && (r_pre == 6'd1);
  assign o_tc    = w_dec && (r_cnt == 8'd1);
  assign o_done  = o_tc && !r_cont;
  assign o_count = r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pre_rld <= '0;
      r_cnt_rld <= '0;
      r_cont    <= 1'b0;
      r_pre     <= '0;
      r_cnt     <= '0;
    end else begin
      if (i_wr_cnt) r_cnt_rld <= i_wdata;
      if (i_wr_pre) begin
        r_pre_rld <= i_wdata[7:2];
        r_cont    <= i_wdata[0];
      end
      if (i_load) begin
        r_pre <= r_pre_rld;
        r_cnt <= r_cnt_rld;
      end else if (i_en && i_tick) begin
        if (r_pre == 6'd1) begin
          r_pre <= r_pre_rld;
          if (r_cnt == 8'd1) r_cnt <= r_cont ? r_cnt_rld : 8'd0;
          else               r_cnt <= r_cnt - 8'd1;
        end else begin
          r_pre <= r_pre - 6'd1;
        end
      end
    end
  end

endmodule

// File: rtl/z8_timer.sv
// Z8-compatible dual timer/counter on the SFR bus (F1h-F5h).
// Define Z8_TIMER_T1_EXT_CLK_EN to let PRE1 bit1 select the synchronised tin edge for T1.
module z8_timer
  import z8_timer_pkg::*;
#(
  parameter int CLK_DIV = 4
)
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] sfr_addr,
  input  logic       sfr_wr,
  input  logic [7:0] sfr_wdata,
  output logic [7:0] sfr_rdata,
  input  logic       tin,
  output logic       tout,
  output logic       irq_t0,
  output logic       irq_t1
);

  localparam int DW = $clog2(CLK_DIV);

  logic [DW-1:0] r_div;
  logic [7:0]    r_tmr;
  logic          r_tout;
  logic          r_irq0, r_irq1;
  logic          w_tick, w_src1;
  logic          w_wr_tmr, w_wr_t0, w_wr_t1, w_wr_pre0, w_wr_pre1;
  logic          w_load0, w_load1;
  logic [7:0]    w_cnt0, w_cnt1;
  logic          w_tc0, w_tc1, w_done0, w_done1;

  assign w_tick    = (r_div == DW'(CLK_DIV - 1));
  assign w_wr_tmr  = sfr_wr && (sfr_addr == TMR_ADDR);
  assign w_wr_t0   = sfr_wr && (sfr_addr == T0_ADDR);
  assign w_wr_t1   = sfr_wr && (sfr_addr == T1_ADDR);
  assign w_wr_pre0 = sfr_wr && (sfr_addr == PRE0_ADDR);
  assign w_wr_pre1 = sfr_wr && (sfr_addr == PRE1_ADDR);
  assign w_load0   = w_wr_tmr && sfr_wdata[TMR_LD0];
  assign w_load1   = w_wr_tmr && sfr_wdata[TMR_LD1];

`ifdef Z8_TIMER_T1_EXT_CLK_EN
  logic [2:0] r_sync;
  logic       r_pre1_int;
  logic       w_tin_edge;

  // Two synchroniser flops, then a third flop for rising-edge detection.
  assign w_tin_edge = r_sync[1] && !r_sync[2];
  assign w_src1     = r_pre1_int ? w_tick : w_tin_edge;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync     <= '0;
      r_pre1_int <= 1'b0;
    end else begin
      r_sync <= {r_sync[1:0], tin};
      if (w_wr_pre1) r_pre1_int <= sfr_wdata[1];
    end
  end
`else
  logic w_unused_tin;
  assign w_unused_tin = tin;
  assign w_src1       = w_tick;
`endif

  z8_timer_channel u_t0 (
    .clk(clk), .reset_n(reset_n),
    .i_wr_cnt(w_wr_t0), .i_wr_pre(w_wr_pre0), .i_wdata(sfr_wdata),
    .i_load(w_load0), .i_tick(w_tick), .i_en(r_tmr[TMR_EN0]),
    .o_count(w_cnt0), .o_tc(w_tc0), .o_done(w_done0)
  );

  z8_timer_channel u_t1 (
    .clk(clk), .reset_n(reset_n),
    .i_wr_cnt(w_wr_t1), .i_wr_pre(w_wr_pre1), .i_wdata(sfr_wdata),
    .i_load(w_load1), .i_tick(w_src1), .i_en(r_tmr[TMR_EN1]),
    .o_count(w_cnt1), .o_tc(w_tc1), .o_done(w_done1)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div  <= '0;
      r_tmr  <= '0;
      r_tout <= 1'b1;
      r_irq0 <= 1'b0;
      r_irq1 <= 1'b0;
    end else begin
      r_div  <= r_div + 1'b1;
      r_irq0 <= w_tc0;
      r_irq1 <= w_tc1;
      if (w_wr_tmr)
        r_tmr <= {sfr_wdata[7:4], sfr_wdata[TMR_EN1], 1'b0, sfr_wdata[TMR_EN0], 1'b0};
      // Single-pass completion wins over a same-edge TMR write that keeps enable set.
      if (w_done0) r_tmr[TMR_EN0] <= 1'b0;
      if (w_done1) r_tmr[TMR_EN1] <= 1'b0;
      case (tout_mode_e'(r_tmr[5:4]))
        TOUT_T0: if (w_tc0) r_tout <= ~r_tout;
        TOUT_T1: if (w_tc1) r_tout <= ~r_tout;
        default: r_tout <= r_tout;
      endcase
    end
  end

  always_comb begin
    sfr_rdata = 8'h00;
    case (sfr_addr)
      TMR_ADDR: sfr_rdata = r_tmr;
      T1_ADDR:  sfr_rdata = w_cnt1;
      T0_ADDR:  sfr_rdata = w_cnt0;
      default:  sfr_rdata = 8'h00;
    endcase
  end

  assign tout   = r_tout;
  assign irq_t0 = r_irq0;
  assign irq_t1 = r_irq1;

endmodule

// File: tb/tb_z8_timer.sv
// Directed bench for z8_timer (CLK_DIV = 4); the external-clock case runs only
// when Z8_TIMER_T1_EXT_CLK_EN is defined.
module tb_z8_timer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] sfr_addr = 8'h00;
  logic       sfr_wr = 1'b0;
  logic [7:0] sfr_wdata = 8'h00;
  logic [7:0] sfr_rdata;
  logic       tin = 1'b0;
  logic       tout, irq_t0, irq_t1;

  int n_cmp = 0;
  int n_err = 0;

  z8_timer #(.CLK_DIV(4)) dut (
    .clk(clk), .reset_n(reset_n), .sfr_addr(sfr_addr), .sfr_wr(sfr_wr),
    .sfr_wdata(sfr_wdata), .sfr_rdata(sfr_rdata), .tin(tin), .tout(tout),
    .irq_t0(irq_t0), .irq_t1(irq_t1)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    sfr_addr = a; sfr_wdata = d; sfr_wr = 1'b1;
    @(negedge clk);
    sfr_wr = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    sfr_addr = a;
    #1;
    d = sfr_rdata;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    logic [7:0] addrs [5] = '{8'hF1, 8'hF2, 8'hF3, 8'hF4, 8'hF5};
    do_reset();
    foreach (addrs[i]) begin
      rd(addrs[i], d);
      n_cmp++;
      if (d !== 8'h00) begin n_err++; $display("FAIL reset_read addr=%h got=%h exp=00", addrs[i], d); end
    end
    n_cmp++;
    if (tout !== 1'b1 || irq_t0 !== 1'b0 || irq_t1 !== 1'b0) begin
      n_err++; $display("FAIL reset_outputs tout=%b irq0=%b irq1=%b exp=1,0,0", tout, irq_t0, irq_t1);
    end
  endtask

  task automatic test_continuous();
    logic [7:0] d;
    int n;
    wr(8'hF5, 8'h05); wr(8'hF4, 8'h03); wr(8'hF1, 8'h03);
    n = 1;
    while (irq_t0 !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    n_cmp++;
    if (n < 10 || n > 13) begin n_err++; $display("FAIL cont_first_irq cycle=%0d exp=10..13", n); end
    rd(8'hF4, d);
    n_cmp++;
    if (d !== 8'h03) begin n_err++; $display("FAIL cont_t0_3 got=%h exp=03", d); end
    rd(8'hF1, d);
    n_cmp++;
    if (d !== 8'h02) begin n_err++; $display("FAIL cont_tmr got=%h exp=02", d); end
    @(negedge clk);
    n_cmp++;
    if (irq_t0 !== 1'b0) begin n_err++; $display("FAIL cont_irq_width got=%b exp=0", irq_t0); end
    repeat (3) @(negedge clk);
    rd(8'hF4, d);
    n_cmp++;
    if (d !== 8'h02) begin n_err++; $display("FAIL cont_t0_2 got=%h exp=02", d); end
    repeat (4) @(negedge clk);
    rd(8'hF4, d);
    n_cmp++;
    if (d !== 8'h01) begin n_err++; $display("FAIL cont_t0_1 got=%h exp=01", d); end
    repeat (4) @(negedge clk);
    rd(8'hF4, d);
    n_cmp++;
    if (irq_t0 !== 1'b1 || d !== 8'h03) begin
      n_err++; $display("FAIL cont_period irq=%b t0=%h exp irq=1 t0=03 after 12 clk", irq_t0, d);
    end
    wr(8'hF1, 8'h00);
  endtask

  task automatic test_single_pass();
    logic [7:0] d;
    int n, hits;
    wr(8'hF5, 8'h04); wr(8'hF4, 8'h02); wr(8'hF1, 8'h03);
    n = 1;
    while (irq_t0 !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    n_cmp++;
    if (n < 6 || n > 9) begin n_err++; $display("FAIL single_irq cycle=%0d exp=6..9", n); end
    hits = 0;
    repeat (100) begin @(negedge clk); if (irq_t0 === 1'b1) hits++; end
    n_cmp++;
    if (hits != 0) begin n_err++; $display("FAIL single_no_more_irq got=%0d exp=0", hits); end
    rd(8'hF1, d);
    n_cmp++;
    if (d !== 8'h00) begin n_err++; $display("FAIL single_tmr got=%h exp=00", d); end
    rd(8'hF4, d);
    n_cmp++;
    if (d !== 8'h00) begin n_err++; $display("FAIL single_t0 got=%h exp=00", d); end
  endtask

  task automatic test_rollover();
    logic [7:0] d;
    int n;
    wr(8'hF3, 8'h03); wr(8'hF2, 8'h00); wr(8'hF1, 8'h0C);
    rd(8'hF2, d);
    n_cmp++;
    if (d !== 8'h00) begin n_err++; $display("FAIL roll_t1_loaded got=%h exp=00", d); end
    n = 1;
    while (n < 300) begin @(negedge clk); n++; end
    rd(8'hF2, d);
    n_cmp++;
    if (d !== 8'hFF) begin n_err++; $display("FAIL roll_prescale64 got=%h exp=FF", d); end
    while (irq_t1 !== 1'b1 && n < 70000) begin @(negedge clk); n++; end
    n_cmp++;
    if (n < 65534 || n > 65537) begin n_err++; $display("FAIL roll_period cycle=%0d exp=65534..65537", n); end
    rd(8'hF2, d);
    n_cmp++;
    if (d !== 8'h00) begin n_err++; $display("FAIL roll_reload got=%h exp=00", d); end
    wr(8'hF1, 8'h00);
  endtask

  task automatic test_tout();
    int n;
    do_reset();
    wr(8'hF5, 8'h05); wr(8'hF4, 8'h01); wr(8'hF1, 8'h13);
    n = 1;
    while (irq_t0 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    n_cmp++;
    if (n < 2 || n > 5 || tout !== 1'b0) begin
      n_err++; $display("FAIL tout_first cycle=%0d tout=%b exp=2..5,0", n, tout);
    end
    @(negedge clk);
    n_cmp++;
    if (irq_t0 !== 1'b0 || tout !== 1'b0) begin
      n_err++; $display("FAIL tout_hold irq=%b tout=%b exp=0,0", irq_t0, tout);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (irq_t0 !== 1'b1 || tout !== 1'b1) begin
      n_err++; $display("FAIL tout_second irq=%b tout=%b exp=1,1", irq_t0, tout);
    end
    wr(8'hF1, 8'h00);
  endtask

  task automatic test_load_collision();
    logic [7:0] d;
    int n;
    wr(8'hF5, 8'h05); wr(8'hF4, 8'h02); wr(8'hF1, 8'h03);
    n = 0;
    rd(8'hF4, d);
    while (d !== 8'h01 && n < 50) begin @(negedge clk); rd(8'hF4, d); n++; end
    n_cmp++;
    if (d !== 8'h01) begin n_err++; $display("FAIL coll_reach1 got=%h exp=01", d); end
    // The count just reached 1 on a tick edge; aim the reload at the next tick edge.
    repeat (2) @(negedge clk);
    wr(8'hF1, 8'h03);
    rd(8'hF4, d);
    n_cmp++;
    if (irq_t0 !== 1'b0 || d !== 8'h02) begin
      n_err++; $display("FAIL coll_load irq=%b t0=%h exp=0,02", irq_t0, d);
    end
    @(negedge clk);
    n_cmp++;
    if (irq_t0 !== 1'b0) begin n_err++; $display("FAIL coll_no_irq got=%b exp=0", irq_t0); end
    wr(8'hF1, 8'h00);
  endtask

  task automatic test_reset_mid_count();
    logic [7:0] d;
    logic [7:0] addrs [5] = '{8'hF1, 8'hF2, 8'hF3, 8'hF4, 8'hF5};
    int hits;
    wr(8'hF5, 8'h05); wr(8'hF4, 8'h03); wr(8'hF3, 8'h05); wr(8'hF2, 8'h02);
    wr(8'hF1, 8'h1F);
    repeat (22) @(negedge clk);
    do_reset();
    foreach (addrs[i]) begin
      rd(addrs[i], d);
      n_cmp++;
      if (d !== 8'h00) begin n_err++; $display("FAIL rst_mid_read addr=%h got=%h exp=00", addrs[i], d); end
    end
    n_cmp++;
    if (tout !== 1'b1) begin n_err++; $display("FAIL rst_mid_tout got=%b exp=1", tout); end
    hits = 0;
    repeat (50) begin @(negedge clk); if (irq_t0 === 1'b1 || irq_t1 === 1'b1) hits++; end
    n_cmp++;
    if (hits != 0) begin n_err++; $display("FAIL rst_mid_no_irq got=%0d exp=0", hits); end
  endtask

`ifdef Z8_TIMER_T1_EXT_CLK_EN
  task automatic test_ext_clk();
    logic [7:0] d;
    do_reset();
    wr(8'hF3, 8'h05); wr(8'hF2, 8'h02); wr(8'hF1, 8'h0C);
    tin = 1'b1; repeat (3) @(negedge clk);
    tin = 1'b0; repeat (3) @(negedge clk);
    rd(8'hF2, d);
    n_cmp++;
    if (d !== 8'h01) begin n_err++; $display("FAIL ext_first_edge got=%h exp=01", d); end
    tin = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (irq_t1 !== 1'b0) begin n_err++; $display("FAIL ext_early got=%b exp=0", irq_t1); end
    @(negedge clk);
    n_cmp++;
    if (irq_t1 !== 1'b1) begin n_err++; $display("FAIL ext_irq got=%b exp=1", irq_t1); end
    tin = 1'b0;
    wr(8'hF1, 8'h00);
  endtask
`endif

  initial begin
    test_reset();
    test_continuous();
    test_single_pass();
    test_tout();
    test_load_collision();
    test_reset_mid_count();
`ifdef Z8_TIMER_T1_EXT_CLK_EN
    test_ext_clk();
`endif
    test_rollover();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
